// File: rtl/multdiv_pkg.sv
// Shared types and defaults for the iterative MULT/DIV unit.
// The optional divide-by-zero shortcut is enabled with MULTDIV_DIVZERO_EN.
package multdiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } md_state_t;

  typedef enum logic {
    OP_MULT,
    OP_DIV
  } md_op_t;

endpackage

// File: rtl/twos_neg.sv
// Conditional two's-complement negate, used for operand magnitudes
// and for the final sign fix-up of product, quotient and remainder.
module twos_neg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             neg,
  output logic [WIDTH-1:0] result
);

  assign result = neg ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed MULT/DIV with HI/LO result registers.
// Define MULTDIV_DIVZERO_EN to add div_zero and the divide-by-zero shortcut.
module mult_div_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MULTDIV_DIVZERO_EN
  ,
  output logic             div_zero
`endif
);

  localparam int AW = 2 * WIDTH + 1;

  md_state_t          state;
  md_state_t          state_nx;
  md_op_t             op_q;
  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   rs_abs;
  logic [WIDTH-1:0]   rt_abs;
  logic [AW-1:0]      acc;
  logic [AW-1:0]      acc_nx;
  logic [AW-1:0]      shl;
  logic [WIDTH:0]     sum;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic               accept;
  logic               dz_hit;
  logic               busy_nx;
  logic               done_nx;

  assign accept = (state == IDLE) && start;

`ifdef MULTDIV_DIVZERO_EN
  logic dz_q;
  assign dz_hit = op && (rt == '0);
`else
  assign dz_hit = 1'b0;
`endif

  twos_neg #(.WIDTH(WIDTH)) u_abs_rs (
    .value  (rs),
    .neg    (rs[WIDTH-1]),
    .result (rs_abs)
  );

  twos_neg #(.WIDTH(WIDTH)) u_abs_rt (
    .value  (rt),
    .neg    (rt[WIDTH-1]),
    .result (rt_abs)
  );

  twos_neg #(.WIDTH(2 * WIDTH)) u_fix_prod (
    .value  (acc[2*WIDTH-1:0]),
    .neg    (sa ^ sb),
    .result (prod)
  );

  // A zero divisor leaves the all-ones quotient unsigned.
  twos_neg #(.WIDTH(WIDTH)) u_fix_quo (
    .value  (acc[WIDTH-1:0]),
    .neg    ((sa ^ sb) && (b != '0)),
    .result (quo)
  );

  twos_neg #(.WIDTH(WIDTH)) u_fix_rem (
    .value  (acc[2*WIDTH-1:WIDTH]),
    .neg    (sa),
    .result (rem)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = dz_hit ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt == CNT_W'(1)) begin
          state_nx = FIX;
        end
      end
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy_nx = (state_nx == RUN) || (state_nx == FIX);
    done_nx = (state == DONE);
  end

  // One shift-add or shift-subtract step of the accumulator.
  always_comb begin
    acc_nx = acc;
    sum    = '0;
    shl    = '0;
    if (op_q == OP_MULT) begin
      sum    = {1'b0, acc[2*WIDTH-1:WIDTH]}
             + (acc[0] ? {1'b0, a} : '0);
      acc_nx = {1'b0, sum, acc[WIDTH-1:1]};
    end else begin
      shl = acc << 1;
      if (shl[AW-1:WIDTH] >= {1'b0, b}) begin
        shl[AW-1:WIDTH] = shl[AW-1:WIDTH] - {1'b0, b};
        shl[0]          = 1'b1;
      end
      acc_nx = shl;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      hi   <= '0;
      lo   <= '0;
      cnt  <= '0;
      acc  <= '0;
      a    <= '0;
      b    <= '0;
      sa   <= 1'b0;
      sb   <= 1'b0;
      op_q <= OP_MULT;
    end else begin
      busy <= busy_nx;
      done <= done_nx;
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_q <= md_op_t'(op);
            a    <= rs_abs;
            b    <= rt_abs;
            sa   <= rs[WIDTH-1];
            sb   <= rt[WIDTH-1];
            cnt  <= CNT_W'(WIDTH);
            acc  <= op ? {(WIDTH + 1)'(0), rs_abs}
                       : {(WIDTH + 1)'(0), rt_abs};
          end
        end
        RUN: begin
          acc <= acc_nx;
          cnt <= cnt - CNT_W'(1);
        end
        FIX: begin
          if (op_q == OP_MULT) begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end else begin
            hi <= rem;
            lo <= quo;
          end
        end
        DONE: begin
        end
      endcase
    end
  end

`ifdef MULTDIV_DIVZERO_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      dz_q     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      if (accept) begin
        dz_q <= dz_hit;
      end
      div_zero <= (state == DONE) && dz_q;
    end
  end
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Vector table plus corner sequences for mult_div_unit.
// Covers both builds of MULTDIV_DIVZERO_EN.
module tb_mult_div_unit;

  typedef struct {
    logic        op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          busy_n;
    logic        dz;
  } vec_t;

  logic        clock;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef MULTDIV_DIVZERO_EN
  logic        div_zero;
`endif

  int   n_assert;
  int   n_fail;
  vec_t exp_q[$];
  vec_t vecs[12];

  mult_div_unit dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .op    (op),
    .rs    (rs),
    .rt    (rt),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
`ifdef MULTDIV_DIVZERO_EN
    ,
    .div_zero (div_zero)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic no_done(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (done) seen++;
    end
    check(name, seen, 0);
  endtask

  task automatic run_op(input vec_t v, input int dup_at);
    vec_t e;
    int   busy_cnt;
    int   got;
    exp_q.push_back(v);
    op = v.op; rs = v.rs; rt = v.rt;
    start = 1'b1;
    busy_cnt = 0;
    got = 0;
    for (int lat = 0; lat < 100; lat++) begin
      @(negedge clock);
      if (lat == 0) begin
        start = 1'b0;
        op = 1'($urandom); rs = $urandom; rt = $urandom;
      end
      if (dup_at >= 0 && lat == dup_at) start = 1'b1;
      if (dup_at >= 0 && lat == dup_at + 1) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        got = 1;
        check("latency", lat, v.lat);
        if (exp_q.size() == 0) begin
          check("queue_nonempty", 0, 1);
        end else begin
          e = exp_q.pop_front();
          check("hi", hi, e.hi);
          check("lo", lo, e.lo);
`ifdef MULTDIV_DIVZERO_EN
          check("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
`endif
        end
        break;
      end
    end
    if (got == 0) begin
      check("done_timeout", 0, 1);
      void'(exp_q.pop_front());
    end
    check("busy_cycles", busy_cnt, v.busy_n);
    @(negedge clock);
    check("done_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    vecs[0]  = '{1'b0, 32'd7, -32'sd3, 32'hFFFFFFFF, 32'hFFFFFFEB, 34, 33, 1'b0};
    vecs[1]  = '{1'b1, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, 33, 1'b0};
    vecs[2]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 34, 33, 1'b0};
    vecs[3]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 34, 33, 1'b0};
    vecs[4]  = '{1'b0, 32'd3, 32'd4, 32'h0, 32'd12, 34, 33, 1'b0};
    vecs[5]  = '{1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 34, 33, 1'b0};
    vecs[6]  = '{1'b1, 32'd7, -32'sd2, 32'd1, 32'hFFFFFFFD, 34, 33, 1'b0};
    vecs[7]  = '{1'b0, 32'h12345678, 32'h10, 32'h1, 32'h23456780, 34, 33, 1'b0};
    vecs[8]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 34, 33, 1'b0};
    vecs[9]  = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h1, 34, 33, 1'b0};
    vecs[10] = '{1'b1, -32'sd100, -32'sd7, 32'hFFFFFFFE, 32'd14, 34, 33, 1'b0};
`ifdef MULTDIV_DIVZERO_EN
    vecs[11] = '{1'b1, 32'd5, 32'd0, 32'hFFFFFFFE, 32'd14, 1, 0, 1'b1};
`else
    vecs[11] = '{1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 34, 33, 1'b0};
`endif

    reset = 1'b1; start = 1'b0; op = 1'b0; rs = '0; rt = '0;
    repeat (3) @(negedge clock);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
`ifdef MULTDIV_DIVZERO_EN
    check("reset_div_zero", {31'd0, div_zero}, 32'd0);
`endif
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i], -1);
      repeat (2) @(negedge clock);
    end

    // Second start mid-operation must be ignored.
    run_op('{1'b0, 32'd9, 32'd11, 32'h0, 32'd99, 34, 33, 1'b0}, 10);
    no_done("extra_done", 40);

    // Reset in the middle of a divide.
    op = 1'b1; rs = 32'd100; rt = 32'd7;
    start = 1'b1;
    for (int lat = 0; lat < 16; lat++) begin
      @(negedge clock);
      if (lat == 0) start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clock);
    check("mid_reset_busy", {31'd0, busy}, 32'd0);
    check("mid_reset_done", {31'd0, done}, 32'd0);
    check("mid_reset_hi", hi, 32'd0);
    check("mid_reset_lo", lo, 32'd0);
    reset = 1'b0;
    no_done("done_after_reset", 40);
    run_op('{1'b0, 32'd3, 32'd4, 32'h0, 32'd12, 34, 33, 1'b0}, -1);

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
